// File: rtl/sequencer_pkg.sv
// Shared state encodings and PC source selectors for the ARMAria instruction sequencer.
package sequencer_pkg;

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        DECODE     = 4'd1,
        EXECUTE    = 4'd2,
        MEMORY     = 4'd3,
        INPUT_WAIT = 4'd4,
        WRITEBACK  = 4'd5,
        INTERRUPT  = 4'd6,
        HALT       = 4'd7
    } state_t;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_VECTOR = 2'd2;

endpackage

// File: rtl/wait_state_counter.sv
// Saturating down-counter that times memory accesses; shared by FETCH and MEMORY.
module wait_state_counter #(
    parameter int WIDTH      = 4,
    parameter int LOAD_VALUE = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic decrement,
    output logic zero
);

    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(LOAD_VALUE);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= RELOAD;
        end else if (load) begin
            count <= RELOAD;
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle phase controller: turns decode outputs into timed strobes, wait states,
// input stalls, interrupt entry and halt handling. Strobes lag the state by one register.
module instruction_sequencer
    import sequencer_pkg::*;
#(
    parameter int ID_WIDTH           = 7,
    parameter int MEM_WAIT_CYCLES    = 2,
    parameter int WAIT_COUNTER_WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ID_WIDTH-1:0] id,
    input  logic                is_memory_access,
    input  logic                allow_write_on_memory,
    input  logic                should_read_from_input_instead_of_memory,
    input  logic                writes_register,
    input  logic                is_branch,
    input  logic                should_take_branch,
    input  logic                is_halt,
    input  logic                input_valid,
    input  logic                interrupt_request,
    input  logic                interrupt_enable,
    output logic                memory_request,
    output logic                instruction_register_load,
    output logic                flag_update_enable,
    output logic                memory_write_strobe,
    output logic                register_write_enable,
    output logic                pc_update,
    output logic [1:0]          pc_select,
    output logic                input_ack,
    output logic                interrupt_ack,
    output logic                halted,
    output logic [3:0]          phase,
    output logic [ID_WIDTH-1:0] latched_id
);

    state_t state, state_next, phase_q;
    logic   cnt_load, cnt_decrement, cnt_zero;
    logic   irq_pending;
    logic   lat_memory, lat_store, lat_input, lat_write, lat_halt, lat_branch;

    wait_state_counter #(
        .WIDTH      (WAIT_COUNTER_WIDTH),
        .LOAD_VALUE (MEM_WAIT_CYCLES)
    ) u_wait_counter (
        .clock     (clock),
        .reset     (reset),
        .load      (cnt_load),
        .decrement (cnt_decrement),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_load      = 1'b0;
        cnt_decrement = 1'b0;
        case (state)
            FETCH: begin
                if (cnt_zero) state_next = DECODE;
                else          cnt_decrement = 1'b1;
            end
            DECODE: state_next = EXECUTE;
            EXECUTE: begin
                if (lat_halt) begin
                    state_next = HALT;
                end else if (lat_memory && lat_input) begin
                    state_next = INPUT_WAIT;
                end else if (lat_memory) begin
                    state_next = MEMORY;
                    cnt_load   = 1'b1;
                end else begin
                    state_next = WRITEBACK;
                end
            end
            MEMORY: begin
                if (cnt_zero) state_next = WRITEBACK;
                else          cnt_decrement = 1'b1;
            end
            INPUT_WAIT: begin
                if (input_valid) state_next = WRITEBACK;
            end
            WRITEBACK: begin
                state_next = irq_pending ? INTERRUPT : FETCH;
                cnt_load   = 1'b1;
            end
            INTERRUPT: begin
                state_next = FETCH;
                cnt_load   = 1'b1;
            end
            HALT: begin
                if (irq_pending) state_next = INTERRUPT;
            end
            default: begin
                state_next = FETCH;
                cnt_load   = 1'b1;
            end
        endcase
    end

    // Decode-time snapshot; the control unit may change its outputs afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            latched_id <= '0;
            lat_memory <= 1'b0;
            lat_store  <= 1'b0;
            lat_input  <= 1'b0;
            lat_write  <= 1'b0;
            lat_halt   <= 1'b0;
            lat_branch <= 1'b0;
        end else if (state == DECODE) begin
            latched_id <= id;
            lat_memory <= is_memory_access;
            lat_store  <= allow_write_on_memory;
            lat_input  <= should_read_from_input_instead_of_memory;
            lat_write  <= writes_register;
            lat_halt   <= is_halt;
            lat_branch <= is_branch & should_take_branch;
        end
    end

    // A new request in the servicing cycle keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_pending <= 1'b0;
        end else begin
            irq_pending <= (interrupt_request & interrupt_enable) |
                           (irq_pending & (state != INTERRUPT));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q                   <= FETCH;
            memory_request            <= 1'b0;
            instruction_register_load <= 1'b0;
            flag_update_enable        <= 1'b0;
            memory_write_strobe       <= 1'b0;
            register_write_enable     <= 1'b0;
            pc_update                 <= 1'b0;
            input_ack                 <= 1'b0;
            interrupt_ack             <= 1'b0;
            halted                    <= 1'b0;
        end else begin
            phase_q                   <= state;
            memory_request            <= (state == FETCH) || (state == MEMORY);
            instruction_register_load <= (state == FETCH) && cnt_zero;
            flag_update_enable        <= (state == EXECUTE);
            memory_write_strobe       <= (state == MEMORY) && cnt_zero && lat_store;
            register_write_enable     <= (state == WRITEBACK) && lat_write;
            pc_update                 <= (state == WRITEBACK) || (state == INTERRUPT);
            input_ack                 <= (state == WRITEBACK) && lat_memory && lat_input;
            interrupt_ack             <= (state == INTERRUPT);
            halted                    <= (state == HALT);
        end
    end

    always_comb begin
        pc_select = PC_NEXT;
        if ((phase_q == WRITEBACK) && lat_branch) pc_select = PC_BRANCH;
        if (phase_q == INTERRUPT)                 pc_select = PC_VECTOR;
    end

    assign phase = phase_q;

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Multi-cycle phase controller for the ARMAria core. It sits beside the control unit and turns its combinational decode outputs into timed strobes: instruction-register load, flag update, memory write, register-bank write and PC update. It inserts memory wait states and stalls on human-interface input. It also services a single interrupt line, and decides whether a halt resumes or stays halted.

Parameters:
ID_WIDTH, 7, width of the decoded instruction ID (debug passthrough only)
MEM_WAIT_CYCLES, 2, extra cycles a memory access is held before data is valid (0..15)
WAIT_COUNTER_WIDTH, 4, width of the wait-state counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id  in  ID_WIDTH  decoded instruction ID, latched at DECODE for debug
is_memory_access  in  1  current instruction loads or stores
allow_write_on_memory  in  1  current instruction is a store
should_read_from_input_instead_of_memory  in  1  current load comes from the human interface
writes_register  in  1  current instruction writes the register bank
is_branch  in  1  current instruction is a branch
should_take_branch  in  1  branch condition result
is_halt  in  1  current instruction is HALT
input_valid  in  1  human interface has data ready (level)
interrupt_request  in  1  external interrupt (level or pulse)
interrupt_enable  in  1  interrupts are allowed
memory_request  out  1  memory port is busy (fetch or data)
instruction_register_load  out  1  capture the fetched instruction
flag_update_enable  out  1  SpecReg update strobe
memory_write_strobe  out  1  one-cycle store commit
register_write_enable  out  1  one-cycle register-bank write
pc_update  out  1  one-cycle PC load
pc_select  out  2  0 = PC+1, 1 = branch target, 2 = interrupt vector
input_ack  out  1  one-cycle acknowledge to the human interface
interrupt_ack  out  1  one-cycle acknowledge of the taken interrupt
halted  out  1  core is in HALT
phase  out  4  current state encoding
latched_id  out  ID_WIDTH  ID captured at DECODE

Behaviour:
- While reset = 0: state = FETCH, counter = MEM_WAIT_CYCLES, all outputs = 0, latched_id = 0, and irq_pending is cleared. On reset release, the FETCH access starts on the first edge.
- Outputs are registered from the state and counter. No output depends combinationally on inputs, except that pc_select is taken from state plus the latched branch decision.
- FETCH: memory_request = 1 for MEM_WAIT_CYCLES+1 cycles; the counter counts down. instruction_register_load = 1 in the final cycle only (counter = 0). Next state is DECODE.
- DECODE (1 cycle): latch id, is_memory_access, allow_write_on_memory, the input-read flag, writes_register, is_halt, and (is_branch & should_take_branch) into internal registers. Next state is EXECUTE.
- EXECUTE (1 cycle): flag_update_enable = 1. Next state, in priority order:
  - halt -> HALT
  - memory access with input read -> INPUT_WAIT
  - memory access -> MEMORY (counter reloaded to MEM_WAIT_CYCLES)
  - otherwise -> WRITEBACK
- MEMORY: memory_request = 1 for MEM_WAIT_CYCLES+1 cycles. memory_write_strobe = 1 in the final cycle only, and only for a store. Next state is WRITEBACK.
- INPUT_WAIT: hold indefinitely until input_valid = 1 is sampled. input_ack = 1 for exactly the following cycle, which is the first WRITEBACK cycle. No memory_request is raised in this state.
- WRITEBACK (1 cycle):
  - register_write_enable = latched writes_register
  - pc_update = 1
  - pc_select = 1 if the latched branch was taken, else 0
  - next state is INTERRUPT if irq_pending, else FETCH
- INTERRUPT (1 cycle): pc_update = 1, pc_select = 2, interrupt_ack = 1, irq_pending cleared. Next state is FETCH.
- HALT: halted = 1 and no strobes. Exit to INTERRUPT when irq_pending = 1; otherwise stay until reset.
- irq_pending:
  - Set on any cycle with interrupt_request & interrupt_enable.
  - A set on the same cycle as the INTERRUPT-state clear wins (stays pending).
  - Multiple requests before service collapse into one.
  - Never serviced mid-instruction.
- Counter:
  - Saturating down-counter; it never wraps below 0.
  - MEM_WAIT_CYCLES = 0 makes FETCH and MEMORY single-cycle.
- Instruction length: a non-memory instruction takes MEM_WAIT_CYCLES+4 cycles (FETCH+DECODE+EXECUTE+WRITEBACK).
- Unused or illegal state encodings go to FETCH on the next edge.

Decomposition:
- Shared package `sequencer_pkg`:
  - state encodings FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, INPUT_WAIT=4, WRITEBACK=5, INTERRUPT=6, HALT=7
  - pc_select constants PC_NEXT=0, PC_BRANCH=1, PC_VECTOR=2
- One natural sub-module: `wait_state_counter` (load, decrement, zero flag), reused for both FETCH and MEMORY.

Test Plan:
- Reset and ALU op: with MEM_WAIT_CYCLES=2, release reset and hold a non-memory, register-writing instruction.
  - instruction_register_load at cycle 3, flag_update_enable at cycle 5
  - register_write_enable and pc_update with pc_select=0 at cycle 6; next FETCH at cycle 7
- Taken branch: should_take_branch=1 and is_branch=1 at DECODE, then both dropped.
  - WRITEBACK pc_select=1 and register_write_enable=0
- Store: memory_write_strobe high exactly one cycle, the 3rd MEMORY cycle; memory_request high all 3 MEMORY cycles.
- Input stall: input-read load, input_valid held 0 for 10 cycles then 1.
  - phase=4 for 10+ cycles
  - input_ack one cycle, then register_write_enable=1
- Interrupt during MEMORY, while also held high through INTERRUPT: WRITEBACK -> INTERRUPT (pc_select=2, interrupt_ack=1) -> FETCH, with irq_pending still set.
- Halt and mid-operation reset:
  - HALT holds halted=1 for 20 cycles
  - an interrupt then exits via INTERRUPT
  - a separate reset pulse during MEMORY clears all outputs immediately (asynchronously)
